line_draw_ctrl: RTL and testbench

Sequencing controller for the Bresenham error datapath (error/y register pair). It accepts a line command and loads the datapath's error and y registers. It then steps the x counter from x0 to x1 and drives the error/y write enables and mux selects once per column. It presents each (xcount, y_coord) pixel to the downstream pixel writer over a valid/ready handshake. Octant normalisation (steep swap, x0<=x1 ordering, ystep sign) is done upstream; this block only walks x forward.

---
 rtl/line_draw_ctrl.sv | 119 +++++++++++
 tb/tb_line_draw_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_draw_ctrl.sv
// Sequencer for the Bresenham error/y datapath: loads the registers, walks
// xcount from x0 to x1 and hands each pixel downstream over valid/ready.
module line_draw_ctrl #(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] x1,
    input  logic             less_than_zero,
    input  logic             pix_ready,
    output logic [WIDTH-1:0] xcount,
    output logic             pix_valid,
    output logic             WE_error_reg,
    output logic             WE_y_reg,
    output logic             e_sel_mux_in,
    output logic             e_sel_mux_out,
    output logic             y_sel_mux_in,
    output logic             busy,
    output logic             done,
    output logic             bad_cmd
);

    typedef enum logic [2:0] {IDLE, LOAD, PLOT, ADVANCE, FIN} state_t;

    state_t           state;
    logic [WIDTH-1:0] x1_q;
    logic             rej_q;
    logic             last;
    logic             hs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            xcount <= '0;
            x1_q   <= '0;
            rej_q  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (x1 >= x0) begin
                            x1_q   <= x1;
                            xcount <= x0;
                            rej_q  <= 1'b0;
                            state  <= LOAD;
                        end else begin
                            rej_q <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
                LOAD: state <= abort ? FIN : PLOT;
                PLOT: begin
                    if (abort)
                        state <= FIN;
                    else if (pix_ready)
                        state <= last ? FIN : ADVANCE;
                end
                ADVANCE: begin
                    if (abort) begin
                        state <= FIN;
                    end else begin
                        xcount <= xcount + 1'b1;
                        state  <= PLOT;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign last = (xcount == x1_q);
    // Abort suppresses the pixel so a same-cycle ready is not a transfer.
    assign hs   = (state == PLOT) && pix_ready && !abort;

    always_comb begin
        pix_valid     = 1'b0;
        WE_error_reg  = 1'b0;
        WE_y_reg      = 1'b0;
        e_sel_mux_in  = 1'b0;
        e_sel_mux_out = 1'b0;
        y_sel_mux_in  = 1'b0;
        done          = (state == FIN);
        bad_cmd       = (state == FIN) && rej_q;
        if (!abort) begin
            case (state)
                LOAD: begin
                    WE_error_reg = 1'b1;
                    WE_y_reg     = 1'b1;
                end
                PLOT: begin
                    pix_valid = 1'b1;
                    if (hs && !last) begin
                        WE_error_reg  = less_than_zero;
                        WE_y_reg      = less_than_zero;
                        e_sel_mux_in  = 1'b1;
                        e_sel_mux_out = 1'b1;
                        y_sel_mux_in  = 1'b1;
                    end
                end
                ADVANCE: begin
                    WE_error_reg = 1'b1;
                    e_sel_mux_in = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_draw_ctrl.sv
// Directed bench for line_draw_ctrl with a behavioural error/y datapath and a
// pixel scoreboard filled from a reference Bresenham walk.
module tb_line_draw_ctrl;
    localparam int W = 13;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         pix_ready = 1'b0;
    logic [W-1:0] x0 = '0, x1 = '0;
    logic         less_than_zero;
    logic [W-1:0] xcount;
    logic         pix_valid, WE_error_reg, WE_y_reg, e_sel_mux_in, e_sel_mux_out;
    logic         y_sel_mux_in, busy, done, bad_cmd;

    logic signed [W-1:0] deltax = '0, deltay = '0, y0 = '0, ystep = '0;
    logic signed [W-1:0] err_q, y_q;

    int tests = 0, fails = 0;
    int hs_cnt = 0, wey_cnt = 0, busy_cnt = 0, done_cnt = 0;
    int exp_x[$], exp_y[$];
    bit stall_prev = 1'b0;
    int prev_x = 0;
    logic [3:0] pat = 4'b1001;

    line_draw_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .x0(x0), .x1(x1),
        .less_than_zero(less_than_zero), .pix_ready(pix_ready), .xcount(xcount),
        .pix_valid(pix_valid), .WE_error_reg(WE_error_reg), .WE_y_reg(WE_y_reg),
        .e_sel_mux_in(e_sel_mux_in), .e_sel_mux_out(e_sel_mux_out),
        .y_sel_mux_in(y_sel_mux_in), .busy(busy), .done(done), .bad_cmd(bad_cmd)
    );

    always #5 clk = ~clk;

    // Error/y register pair as steered by the controller's enables and selects.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= '0;
            y_q   <= '0;
        end else begin
            if (WE_error_reg)
                err_q <= !e_sel_mux_in ? (deltax >>> 1) - deltay
                       : e_sel_mux_out ? err_q + deltax : err_q - deltay;
            if (WE_y_reg)
                y_q <= y_sel_mux_in ? y_q + ystep : y0;
        end
    end
    assign less_than_zero = err_q[W-1];

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int outs_all();
        return int'({xcount, pix_valid, WE_error_reg, WE_y_reg, e_sel_mux_in,
                     e_sel_mux_out, y_sel_mux_in, busy, done, bad_cmd});
    endfunction

    // Textbook Bresenham for a shallow, x-forward line; n<0 means all pixels.
    task automatic push_exp(input int ax0, input int ax1, input int ay0, input int astep,
                            input int adx, input int ady, input int n);
        int e = adx / 2;
        int y = ay0;
        int k = 0;
        for (int x = ax0; x <= ax1 && (n < 0 || k < n); x++) begin
            exp_x.push_back(x);
            exp_y.push_back(y);
            k++;
            e -= ady;
            if (e < 0) begin
                y += astep;
                e += adx;
            end
        end
    endtask

    task automatic setup(input int ax0, input int ax1, input int ay0, input int astep,
                         input int adx, input int ady, input int n);
        x0 = W'(ax0); x1 = W'(ax1); y0 = W'(ay0); ystep = W'(astep);
        deltax = W'(adx); deltay = W'(ady);
        exp_x.delete(); exp_y.delete();
        push_exp(ax0, ax1, ay0, astep, adx, ady, n);
        hs_cnt = 0; wey_cnt = 0; busy_cnt = 0; done_cnt = 0;
    endtask

    // cyc counts edges from the one after which start is presented.
    task automatic run_line(input bit tog, output int cyc, output int bad);
        pix_ready = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); cyc++; #1;
            start = 1'b0;
            if (tog) pix_ready = pat[cyc % 4];
        end while (!done && cyc < 200);
        bad = int'(bad_cmd);
        chk("done_seen", int'(done), 1);
        @(posedge clk); #1;
        pix_ready = 1'b1;
        chk("done_one_cycle", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            stall_prev = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (WE_y_reg) wey_cnt++;
            if (stall_prev) begin
                chk("stall_valid", int'(pix_valid), 1);
                chk("stall_xcount", int'(xcount), prev_x);
            end
            if (pix_valid && !pix_ready)
                chk("stall_we", int'({WE_error_reg, WE_y_reg}), 0);
            stall_prev = pix_valid && !pix_ready;
            prev_x = int'(xcount);
            if (pix_valid && pix_ready) begin
                hs_cnt++;
                chk("sb_pending", int'(exp_x.size() > 0), 1);
                if (exp_x.size() > 0) begin
                    chk("pix_x", int'(xcount), exp_x.pop_front());
                    chk("pix_y", int'(y_q), exp_y.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, bad;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("reset_outputs", outs_all(), 0);
        rst = 1'b1;

        // Line (0,0)->(5,2), ready always high
        setup(0, 5, 0, 1, 5, 2, -1);
        run_line(1'b0, cyc, bad);
        chk("l1_done_latency", cyc, 13);
        chk("l1_bad_cmd", bad, 0);
        chk("l1_handshakes", hs_cnt, 6);
        chk("l1_sb_empty", exp_x.size(), 0);
        chk("l1_done_pulses", done_cnt, 1);

        // Same line with back-pressure
        setup(0, 5, 0, 1, 5, 2, -1);
        run_line(1'b1, cyc, bad);
        chk("l2_handshakes", hs_cnt, 6);
        chk("l2_sb_empty", exp_x.size(), 0);
        chk("l2_bad_cmd", bad, 0);

        // Single-pixel line at (7,3)
        setup(7, 7, 3, 1, 0, 0, -1);
        run_line(1'b0, cyc, bad);
        chk("l3_handshakes", hs_cnt, 1);
        chk("l3_sb_empty", exp_x.size(), 0);
        chk("l3_we_y_count", wey_cnt, 1);
        chk("l3_bad_cmd", bad, 0);

        // Rejected command x1<x0
        setup(9, 4, 0, 1, 0, 0, -1);
        run_line(1'b0, cyc, bad);
        chk("l4_done_latency", cyc, 1);
        chk("l4_bad_cmd", bad, 1);
        chk("l4_handshakes", hs_cnt, 0);
        chk("l4_busy_cycles", busy_cnt, 1);

        // Abort during the 4th PLOT of (0,0)->(20,-7)
        setup(0, 20, 0, -1, 20, 7, 3);
        pix_ready = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 1;
        while (!(pix_valid && hs_cnt == 3) && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        chk("l5_reach_plot4", int'(pix_valid) + hs_cnt, 4);
        abort = 1'b1;
        #1 chk("l5_abort_quiet", int'({WE_error_reg, WE_y_reg, pix_valid}), 0);
        @(posedge clk); #1 abort = 1'b0;
        chk("l5_done", int'(done), 1);
        chk("l5_bad_cmd", int'(bad_cmd), 0);
        @(posedge clk); #1;
        chk("l5_idle", int'({busy, done}), 0);
        chk("l5_handshakes", hs_cnt, 3);
        chk("l5_sb_empty", exp_x.size(), 0);

        setup(0, 3, 5, 1, 3, 1, -1);
        run_line(1'b0, cyc, bad);
        chk("l5r_handshakes", hs_cnt, 4);
        chk("l5r_sb_empty", exp_x.size(), 0);

        // Asynchronous reset while in ADVANCE
        setup(0, 10, 2, 1, 10, 4, -1);
        pix_ready = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 1;
        while (!(hs_cnt >= 2 && !pix_valid && busy) && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        chk("l6_in_advance", int'(busy && !pix_valid && hs_cnt >= 2), 1);
        #2 rst = 1'b0;
        #1 chk("l6_async_clear", outs_all(), 0);
        repeat (2) @(posedge clk);
        #1 chk("l6_no_done", done_cnt + int'(done), 0);
        rst = 1'b1;
        setup(2, 6, 1, 1, 4, 3, -1);
        run_line(1'b0, cyc, bad);
        chk("l6r_done_latency", cyc, 11);
        chk("l6r_handshakes", hs_cnt, 5);
        chk("l6r_sb_empty", exp_x.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
